mem_readout_arb: RTL and testbench
==================================

MEM_READOUT_ARB -- requirements
Module: mem_readout_arb

Interface
Parameters (name, default, meaning):
REQ-001 NCH, 12, number of source memories (2..16).
REQ-002 DW, 45, memory data width.
REQ-003 AW, 6, per-memory address width; the item count uses the same width.
REQ-004 BXW, 3, bunch-crossing tag width.
REQ-005 RR, 0, arbitration mode: 0 fixed priority (lowest index first), 1 round-robin.
REQ-006 Derived constant CW = 4 (channel tag width); NCH SHALL NOT exceed 16.

Ports (name, direction, width, meaning):
REQ-007 clk  in  1  processing clock; reset is asynchronous and active-high.
REQ-008 reset  in  1  asynchronous active-high reset.
REQ-009 start  in  1  single-cycle pulse that begins a new event.
REQ-010 bx  in  BXW  crossing number, latched on start.
REQ-011 nitems  in  NCH*AW  per-channel item counts (channel k at [k*AW +: AW]), latched on start.
REQ-012 rd_addr  out  NCH*AW  per-channel read address.
REQ-013 rd_data  in  NCH*DW  per-channel memory data; synchronous RAM, valid 1 cycle after rd_addr.
REQ-014 out_data  out  BXW+CW+DW  merged word {bx, channel, data}.
REQ-015 out_valid  out  1  out_data is valid.
REQ-016 out_ready  in  1  sink accepts the word; a transfer occurs when out_valid&out_ready.
REQ-017 busy  out  1  an event is in progress.
REQ-018 done  out  1  level; all items of the current event have been transferred.
REQ-019 aborted  out  1  one-cycle pulse; start arrived while busy.

Function
REQ-020 FSM states are IDLE, SETUP, RUN and DONE. Transitions:
- IDLE→SETUP on start.
- SETUP lasts exactly 2 cycles, then →RUN.
- RUN→DONE when remaining counts, in-flight reads and output buffer are all empty.
- DONE→SETUP on start.
REQ-021 On start, the block latches bx and nitems into remaining[k] and clears every rd_addr to 0.
REQ-022 In SETUP, no reads are issued and out_valid stays 0.
REQ-023 A channel is eligible when its remaining count is non-zero.
REQ-024 In RUN, each cycle the block issues at most one read, to one eligible channel, and only if (buffer occupancy + reads in flight) < 2.
REQ-025 Fixed-priority mode (RR=0) grants the lowest-index eligible channel.
REQ-026 Round-robin mode (RR=1) grants the first eligible channel after the last granted channel, wrapping from NCH-1 to 0. The pointer is 0 after reset and after start.
REQ-027 On grant, rd_addr[k] is presented in that cycle. At the clock edge, rd_addr[k] increments by 1 and remaining[k] decrements by 1.
REQ-028 The granted channel index is pipelined one cycle alongside the read. The next cycle, the word {bx_latched, chan, rd_data[chan]} is written into the 2-entry output FIFO.
REQ-029 out_data and out_valid are driven from the FIFO head, so latency is 2 cycles from grant to out_valid when the FIFO is empty.
REQ-030 With out_ready held at 1, the block sustains one word per cycle.
REQ-031 When out_ready=0, the head word is held stable; no word is lost, duplicated or reordered.
REQ-032 A channel with nitems=0 is never granted and never drives its address.
REQ-033 A channel with nitems=2^AW-1 reads addresses 0..2^AW-2; the address does not wrap.
REQ-034 done rises in the first cycle after the final transfer, and stays 1 until the next start.
REQ-035 An event with all counts 0 goes to DONE directly after SETUP, with no out_valid.
REQ-036 busy=1 in SETUP and RUN, and 0 in IDLE and DONE.
REQ-037 Start during SETUP or RUN:
- pulse aborted for one cycle;
- flush the FIFO and in-flight reads (no output);
- relatch inputs;
- restart SETUP.
REQ-038 Start coinciding with the final transfer: the transfer completes, aborted stays 0, and the block goes to SETUP.

Reset
REQ-039 While reset=1:
- state=IDLE;
- all rd_addr=0, all remaining=0;
- FIFO empty;
- out_valid=0, out_data=0;
- busy=0, done=0, aborted=0;
- RR pointer=0, latched bx=0.
REQ-040 Reset takes effect asynchronously; outputs are defined without a clock edge.
REQ-041 After reset deassertion, the block stays in IDLE until start.

Verification
REQ-042 NCH=12, RR=0, bx=5, counts ch0=2, ch3=1, others 0, out_ready=1 → words (5,0,@0), (5,0,@1), (5,3,@0), with the first out_valid 4 cycles after start; then done=1.
REQ-043 RR=1, ch1=3, ch2=3 → channel order 1,2,1,2,1,2 with addresses 0,0,1,1,2,2.
REQ-044 Backpressure: ch0=6 with out_ready toggling 1,0,0,1,... → exactly 6 words, addresses 0..5 in order, out_data stable while stalled.
REQ-045 All counts 0 → done=1 at cycle 3 after start, out_valid never 1.
REQ-046 Start issued mid-RUN after 2 of 10 words → aborted pulse, no stale words; the new event's words begin from address 0.
REQ-047 Reset asserted mid-RUN without a clock edge → out_valid=0, busy=0, rd_addr=0 immediately.

Source files
------------

// File: rtl/mem_readout_arb.sv
// mem_readout_arb: drains per-channel readout memories into one merged
// stream of {bx, channel, data} words. One read per cycle at most, kept
// within a 2-word credit (output FIFO occupancy plus reads in flight).
module mem_readout_arb #(
  parameter int NCH = 12,
  parameter int DW  = 45,
  parameter int AW  = 6,
  parameter int BXW = 3,
  parameter int RR  = 0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [BXW-1:0]      bx,
  input  logic [NCH*AW-1:0]   nitems,
  output logic [NCH*AW-1:0]   rd_addr,
  input  logic [NCH*DW-1:0]   rd_data,
  output logic [BXW+4+DW-1:0] out_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                busy,
  output logic                done,
  output logic                aborted
);

  localparam int CW    = 4;
  localparam int OW    = BXW + CW + DW;
  localparam int NSLOT = 1 << CW;

  typedef enum logic [1:0] {IDLE, SETUP, RUN, DONE} state_t;

  state_t          state, state_nx;
  logic            setup_2nd;
  logic [AW-1:0]   remaining [NCH];
  logic [AW-1:0]   addr      [NCH];
  logic [BXW-1:0]  bx_q;
  logic [CW-1:0]   rr_ptr;
  logic            infl_v;
  logic [CW-1:0]   infl_ch;
  logic [OW-1:0]   fifo_mem  [2];
  logic            fifo_wp, fifo_rp;
  logic [1:0]      fifo_cnt;

  logic [NSLOT-1:0] elig;
  logic             any_elig;
  logic [CW-1:0]    arb_base, arb_idx, gnt_ch;
  logic [CW:0]      arb_sum;
  logic             arb_found, gnt_v;
  logic             pop, push, finish, abort_now;
  logic [1:0]       occ;

  // Eligibility vector and packed address output
  always_comb begin
    elig    = '0;
    rd_addr = '0;
    for (int unsigned k = 0; k < NCH; k++) begin
      elig[k]               = (remaining[k] != '0);
      rd_addr[k*AW +: AW]   = addr[k];
    end
    any_elig = |elig;
  end

  // Arbiter: scan eligible channels starting at the base (0 or rr_ptr)
  always_comb begin
    arb_base  = (RR != 0) ? rr_ptr : '0;
    arb_found = 1'b0;
    gnt_ch    = '0;
    arb_sum   = '0;
    arb_idx   = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      arb_sum = {1'b0, arb_base} + (CW+1)'(i);
      if (arb_sum >= (CW+1)'(NCH)) arb_sum = arb_sum - (CW+1)'(NCH);
      arb_idx = arb_sum[CW-1:0];
      if (!arb_found && elig[arb_idx]) begin
        arb_found = 1'b1;
        gnt_ch    = arb_idx;
      end
    end
  end

  // Credit, completion and abort decisions; head-of-FIFO outputs
  always_comb begin
    out_valid = (fifo_cnt != 2'd0);
    out_data  = out_valid ? fifo_mem[fifo_rp] : '0;
    pop       = out_valid & out_ready;
    push      = infl_v;
    // A word leaving this cycle frees its slot for a read issued this cycle,
    // which is what lets a ready sink see one word per cycle.
    occ       = fifo_cnt - {1'b0, pop} + {1'b0, infl_v};
    gnt_v     = (state == RUN) && !start && arb_found && (occ < 2'd2);
    finish    = (state == RUN) && !any_elig && !infl_v &&
                ((fifo_cnt == 2'd0) || ((fifo_cnt == 2'd1) && pop));
    abort_now = start && ((state == SETUP) || ((state == RUN) && !finish));
    busy      = (state == SETUP) || (state == RUN);
    done      = (state == DONE);
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = SETUP;
      SETUP:   if (start) state_nx = SETUP;
               else if (setup_2nd) state_nx = RUN;
      RUN:     if (start) state_nx = SETUP;
               else if (finish) state_nx = DONE;
      DONE:    if (start) state_nx = SETUP;
      default: state_nx = IDLE;
    endcase
  end

  // State register, setup cycle counter and abort pulse
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      setup_2nd <= 1'b0;
      aborted   <= 1'b0;
    end else begin
      state     <= state_nx;
      aborted   <= abort_now;
      if (start)                setup_2nd <= 1'b0;
      else if (state == SETUP)  setup_2nd <= 1'b1;
    end
  end

  // Event latch, per-channel counters/addresses and read pipeline
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bx_q    <= '0;
      rr_ptr  <= '0;
      infl_v  <= 1'b0;
      infl_ch <= '0;
      for (int unsigned k = 0; k < NCH; k++) begin
        remaining[k] <= '0;
        addr[k]      <= '0;
      end
    end else if (start) begin
      bx_q    <= bx;
      rr_ptr  <= '0;
      infl_v  <= 1'b0;
      for (int unsigned k = 0; k < NCH; k++) begin
        remaining[k] <= nitems[k*AW +: AW];
        addr[k]      <= '0;
      end
    end else begin
      infl_v  <= gnt_v;
      infl_ch <= gnt_ch;
      if (gnt_v) begin
        addr[gnt_ch]      <= addr[gnt_ch] + 1'b1;
        remaining[gnt_ch] <= remaining[gnt_ch] - 1'b1;
        rr_ptr            <= (gnt_ch == CW'(NCH-1)) ? '0 : gnt_ch + 1'b1;
      end
    end
  end

  // Two-entry output FIFO; start flushes it
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fifo_mem[0] <= '0;
      fifo_mem[1] <= '0;
      fifo_wp     <= 1'b0;
      fifo_rp     <= 1'b0;
      fifo_cnt    <= 2'd0;
    end else if (start) begin
      fifo_wp  <= 1'b0;
      fifo_rp  <= 1'b0;
      fifo_cnt <= 2'd0;
    end else begin
      if (push) begin
        fifo_mem[fifo_wp] <= {bx_q, infl_ch, rd_data[int'(infl_ch)*DW +: DW]};
        fifo_wp           <= ~fifo_wp;
      end
      if (pop) fifo_rp <= ~fifo_rp;
      fifo_cnt <= fifo_cnt + {1'b0, push} - {1'b0, pop};
    end
  end

endmodule

// File: tb/tb_mem_readout_arb.sv
// Bench for mem_readout_arb: one fixed-priority and one round-robin instance
// share stimulus; a word-order model per instance is built from the counts.
module tb_mem_readout_arb;

  localparam int NCH = 12;
  localparam int DW  = 45;
  localparam int AW  = 6;
  localparam int BXW = 3;
  localparam int OW  = BXW + 4 + DW;
  localparam int QN  = 1024;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  logic out_ready = 1'b0;
  logic [BXW-1:0]    bx = '0;
  logic [NCH*AW-1:0] nitems = '0;

  logic [1:0][NCH*AW-1:0] rd_addr_a;
  logic [1:0][NCH*DW-1:0] rd_data_a;
  logic [1:0][OW-1:0]     out_data_a;
  logic [1:0]             out_valid_a, busy_a, done_a, aborted_a;

  mem_readout_arb #(.NCH(NCH), .DW(DW), .AW(AW), .BXW(BXW), .RR(0)) dut0 (
    .clk(clk), .reset(reset), .start(start), .bx(bx), .nitems(nitems),
    .rd_addr(rd_addr_a[0]), .rd_data(rd_data_a[0]), .out_data(out_data_a[0]),
    .out_valid(out_valid_a[0]), .out_ready(out_ready), .busy(busy_a[0]),
    .done(done_a[0]), .aborted(aborted_a[0]));

  mem_readout_arb #(.NCH(NCH), .DW(DW), .AW(AW), .BXW(BXW), .RR(1)) dut1 (
    .clk(clk), .reset(reset), .start(start), .bx(bx), .nitems(nitems),
    .rd_addr(rd_addr_a[1]), .rd_data(rd_data_a[1]), .out_data(out_data_a[1]),
    .out_valid(out_valid_a[1]), .out_ready(out_ready), .busy(busy_a[1]),
    .done(done_a[1]), .aborted(aborted_a[1]));

  initial forever #5 clk = ~clk;

  // Memory contents: channel and address are visible in the data word
  function automatic logic [DW-1:0] memf(input int k, input int a);
    logic [34:0] h;
    h = 35'(k * 1000003 + a * 7919 + 12345);
    return {4'(k), 6'(a), h};
  endfunction

  // Synchronous RAMs, one per channel per instance
  always @(posedge clk)
    for (int i = 0; i < 2; i++)
      for (int k = 0; k < NCH; k++)
        rd_data_a[i][k*DW +: DW] <= memf(k, int'(rd_addr_a[i][k*AW +: AW]));

  int errors = 0;
  int checks = 0;

  logic [OW-1:0] exp_w [2][QN];
  logic [OW-1:0] log_w [2][QN];
  int head [2], tail [2], log_n [2], first_v [2], done_c [2];
  bit active [2], ev_done [2], exp_abort [2], stall_prev [2], final_prev [2];
  logic [OW-1:0] prev_data [2];
  int n_lat [NCH];
  int st_n  [NCH];
  logic [BXW-1:0] st_bx;
  bit do_start, start_on_final;
  int ready_mode, rpat, cyc, saw_abort;

  task automatic check(input bit ok, input string name,
                       input longint unsigned act, input longint unsigned req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0h required %0h at %0t", name, act, req, $time);
    end
  endtask

  // Expected word order for one event: fixed priority drains channels in
  // index order; round-robin takes the next non-empty channel after the last.
  task automatic load_model(input int i);
    int rem [NCH];
    int adr [NCH];
    int p, k;
    bit found;
    head[i] = 0;
    tail[i] = 0;
    for (int c = 0; c < NCH; c++) begin rem[c] = st_n[c]; adr[c] = 0; end
    if (i == 0) begin
      for (int c = 0; c < NCH; c++)
        for (int a = 0; a < rem[c]; a++) begin
          exp_w[i][tail[i]] = {st_bx, 4'(c), memf(c, a)};
          tail[i]++;
        end
    end else begin
      p = 0;
      do begin
        found = 0;
        for (int j = 0; j < NCH; j++) begin
          k = (p + j) % NCH;
          if (!found && rem[k] > 0) begin
            found = 1;
            exp_w[i][tail[i]] = {st_bx, 4'(k), memf(k, adr[k])};
            tail[i]++;
            adr[k]++;
            rem[k]--;
            p = (k + 1) % NCH;
          end
        end
      end while (found);
    end
  endtask

  task automatic check_outputs();
    bit ok;
    int a;
    for (int i = 0; i < 2; i++) begin
      check(aborted_a[i] == exp_abort[i], "aborted", aborted_a[i], exp_abort[i]);
      exp_abort[i] = 0;
      if (i == 0 && aborted_a[0]) saw_abort++;
      if (stall_prev[i])
        check(out_valid_a[i] && out_data_a[i] == prev_data[i], "stall_hold",
              out_data_a[i], prev_data[i]);
      if (out_valid_a[i])
        check(head[i] < tail[i], "no_spurious_word", out_data_a[i], 0);
      if (active[i] && head[i] < tail[i])
        check(busy_a[i] && !done_a[i], "busy_mid_event", {busy_a[i], done_a[i]}, 2'b10);
      if (final_prev[i])
        check(done_a[i] && !busy_a[i], "done_after_final", {busy_a[i], done_a[i]}, 2'b01);
      if (active[i] && head[i] == tail[i] && done_a[i]) begin
        active[i]  = 0;
        ev_done[i] = 1;
      end
      if (!active[i])
        check(!busy_a[i] && !out_valid_a[i] && done_a[i] == ev_done[i], "idle_outputs",
              {busy_a[i], out_valid_a[i], done_a[i]}, {2'b00, ev_done[i]});
      ok = 1;
      for (int k = 0; k < NCH; k++) begin
        a = int'(rd_addr_a[i][k*AW +: AW]);
        if (a > n_lat[k]) ok = 0;
        if (n_lat[k] == 0 && a != 0) ok = 0;
      end
      check(ok, "addr_range", rd_addr_a[i][63:0], 0);
      if (out_valid_a[i] && first_v[i] < 0) first_v[i] = cyc;
      if (done_a[i] && done_c[i] < 0) done_c[i] = cyc;
    end
  endtask

  // One clock: check outputs, drive inputs, advance the model for this edge
  task automatic step();
    bit r, xfer;
    logic [OW-1:0] e;
    @(negedge clk);
    cyc++;
    check_outputs();
    case (ready_mode)
      0:       r = 1'b1;
      1:       r = (rpat % 3 == 0);
      default: r = ($urandom_range(0, 3) != 0);
    endcase
    rpat++;
    out_ready = r;
    if (start_on_final && out_valid_a[0] && r && tail[0] - head[0] == 1) begin
      do_start = 1;
      start_on_final = 0;
    end
    start = do_start;
    if (do_start) begin
      bx = st_bx;
      for (int k = 0; k < NCH; k++) nitems[k*AW +: AW] = AW'(st_n[k]);
    end
    for (int i = 0; i < 2; i++) begin
      xfer = out_valid_a[i] && r;
      final_prev[i] = 0;
      if (xfer) begin
        e = (head[i] < tail[i]) ? exp_w[i][head[i]] : '0;
        check(head[i] < tail[i] && out_data_a[i] == e, "word", out_data_a[i], e);
        if (log_n[i] < QN) begin log_w[i][log_n[i]] = out_data_a[i]; log_n[i]++; end
        if (head[i] < tail[i]) begin
          head[i]++;
          if (head[i] == tail[i]) final_prev[i] = 1;
        end
      end
      stall_prev[i] = out_valid_a[i] && !r;
      prev_data[i]  = out_data_a[i];
    end
    if (do_start) begin
      for (int i = 0; i < 2; i++) begin
        exp_abort[i]  = active[i] && (head[i] < tail[i]);
        load_model(i);
        active[i]     = 1;
        ev_done[i]    = 0;
        stall_prev[i] = 0;
        final_prev[i] = 0;
        log_n[i]      = 0;
        first_v[i]    = -1;
        done_c[i]     = -1;
      end
      for (int k = 0; k < NCH; k++) n_lat[k] = st_n[k];
      cyc = -1;
      do_start = 0;
    end
  endtask

  task automatic clear_counts();
    for (int k = 0; k < NCH; k++) st_n[k] = 0;
  endtask

  task automatic begin_event(input logic [BXW-1:0] b);
    st_bx = b;
    do_start = 1;
    step();
  endtask

  task automatic run_until_idle(input int budget);
    int c = 0;
    while ((active[0] || active[1]) && c < budget) begin step(); c++; end
    check(!active[0] && !active[1], "event_timeout", c, budget);
  endtask

  task automatic random_counts();
    for (int k = 0; k < NCH; k++)
      st_n[k] = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 7)) : 0;
    st_bx = BXW'($urandom_range(0, 7));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int g;
    for (int i = 0; i < 2; i++) begin
      head[i] = 0; tail[i] = 0; log_n[i] = 0; first_v[i] = -1; done_c[i] = -1;
      active[i] = 0; ev_done[i] = 0; exp_abort[i] = 0; stall_prev[i] = 0; final_prev[i] = 0;
      prev_data[i] = '0;
    end
    for (int k = 0; k < NCH; k++) begin n_lat[k] = 0; st_n[k] = 0; end
    do_start = 0; start_on_final = 0; ready_mode = 0; rpat = 0; cyc = 0; saw_abort = 0;
    st_bx = '0;

    // Reset: outputs defined before any clock edge
    #1 reset = 1'b1;
    #1;
    for (int i = 0; i < 2; i++)
      check(out_valid_a[i] == 0 && busy_a[i] == 0 && done_a[i] == 0 && aborted_a[i] == 0 &&
            out_data_a[i] == '0 && rd_addr_a[i] == '0, "reset_state",
            {out_valid_a[i], busy_a[i], done_a[i], aborted_a[i]}, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (3) step();

    // Fixed priority example: ch0=2, ch3=1, bx=5
    clear_counts(); st_n[0] = 2; st_n[3] = 1; ready_mode = 0;
    begin_event(3'd5);
    run_until_idle(200);
    check(first_v[0] == 4, "first_valid_latency", first_v[0], 4);
    check(first_v[1] == 4, "first_valid_latency_rr", first_v[1], 4);
    check(done_c[0] == 7, "done_cycle", done_c[0], 7);
    check(log_n[0] == 3, "word_count_ex1", log_n[0], 3);
    check(log_w[0][0] == {3'd5, 4'd0, memf(0, 0)}, "ex1_w0", log_w[0][0], {3'd5, 4'd0, memf(0, 0)});
    check(log_w[0][1] == {3'd5, 4'd0, memf(0, 1)}, "ex1_w1", log_w[0][1], {3'd5, 4'd0, memf(0, 1)});
    check(log_w[0][2] == {3'd5, 4'd3, memf(3, 0)}, "ex1_w2", log_w[0][2], {3'd5, 4'd3, memf(3, 0)});
    check(log_w[1][1] == {3'd5, 4'd3, memf(3, 0)}, "ex1_rr_w1", log_w[1][1], {3'd5, 4'd3, memf(3, 0)});
    repeat (2) step();

    // Round-robin alternation: ch1=3, ch2=3
    clear_counts(); st_n[1] = 3; st_n[2] = 3;
    begin_event(3'd2);
    run_until_idle(200);
    for (int j = 0; j < 6; j++)
      check(log_w[1][j] == {3'd2, 4'(1 + j % 2), memf(1 + j % 2, j / 2)}, "rr_order",
            log_w[1][j], {3'd2, 4'(1 + j % 2), memf(1 + j % 2, j / 2)});

    // Backpressure: ready pattern 1,0,0
    clear_counts(); st_n[0] = 6; ready_mode = 1; rpat = 0;
    begin_event(3'd7);
    run_until_idle(300);
    check(log_n[0] == 6, "bp_word_count", log_n[0], 6);
    for (int j = 0; j < 6; j++)
      check(log_w[0][j] == {3'd7, 4'd0, memf(0, j)}, "bp_addr_order", log_w[0][j], {3'd7, 4'd0, memf(0, j)});

    // All counts zero
    clear_counts(); ready_mode = 0;
    begin_event(3'd1);
    run_until_idle(50);
    check(done_c[0] == 3, "empty_done_cycle", done_c[0], 3);
    check(first_v[0] == -1 && first_v[1] == -1, "empty_no_valid", first_v[0], -1);

    // Abort mid-run after two words
    clear_counts(); st_n[0] = 4; st_n[5] = 6;
    begin_event(3'd6);
    g = 0;
    while (log_n[0] < 2 && g < 200) begin step(); g++; end
    check(log_n[0] >= 2, "abort_wait", log_n[0], 2);
    g = saw_abort;
    clear_counts(); st_n[2] = 3; st_bx = 3'd1; do_start = 1;
    step();
    run_until_idle(200);
    check(saw_abort == g + 1, "abort_pulse_seen", saw_abort - g, 1);
    check(log_n[0] == 3, "abort_new_count", log_n[0], 3);
    check(log_w[0][0] == {3'd1, 4'd2, memf(2, 0)}, "abort_new_first", log_w[0][0], {3'd1, 4'd2, memf(2, 0)});

    // Start coinciding with the final transfer: no abort
    clear_counts(); st_n[1] = 2;
    begin_event(3'd3);
    clear_counts(); st_n[4] = 2; st_bx = 3'd4; start_on_final = 1;
    g = saw_abort;
    begin
      int c = 0;
      while (start_on_final && c < 200) begin step(); c++; end
    end
    check(!start_on_final, "final_start_wait", start_on_final, 0);
    run_until_idle(200);
    check(saw_abort == g, "final_start_no_abort", saw_abort - g, 0);
    check(log_n[0] == 2 && log_w[0][0] == {3'd4, 4'd4, memf(4, 0)}, "final_start_next",
          log_w[0][0], {3'd4, 4'd4, memf(4, 0)});

    // Maximum count: address stops at 2^AW-1 after 2^AW-1 reads
    clear_counts(); st_n[11] = 63; ready_mode = 2;
    begin_event(3'd2);
    run_until_idle(800);
    check(rd_addr_a[0][11*AW +: AW] == 6'd63, "max_count_addr", rd_addr_a[0][11*AW +: AW], 63);
    check(rd_addr_a[1][11*AW +: AW] == 6'd63, "max_count_addr_rr", rd_addr_a[1][11*AW +: AW], 63);

    // Randomised events, every other one interrupted by a new start
    for (int ev = 0; ev < 8; ev++) begin
      random_counts();
      begin_event(st_bx);
      if (ev % 2 == 1) begin
        repeat ($urandom_range(3, 15)) step();
        if (active[0] && head[0] < tail[0]) begin
          random_counts();
          do_start = 1;
          step();
        end
      end
      run_until_idle(2000);
    end

    // Asynchronous reset in the middle of a run
    clear_counts(); st_n[0] = 20; ready_mode = 0;
    begin_event(3'd5);
    repeat (8) step();
    #2 reset = 1'b1;
    #1;
    for (int i = 0; i < 2; i++)
      check(out_valid_a[i] == 0 && busy_a[i] == 0 && rd_addr_a[i] == '0 && done_a[i] == 0 &&
            aborted_a[i] == 0, "async_reset",
            {out_valid_a[i], busy_a[i], done_a[i], aborted_a[i]}, 0);
    for (int i = 0; i < 2; i++) begin
      active[i] = 0; ev_done[i] = 0; stall_prev[i] = 0; final_prev[i] = 0; exp_abort[i] = 0;
      head[i] = 0; tail[i] = 0;
    end
    for (int k = 0; k < NCH; k++) n_lat[k] = 0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (4) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
